// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester arbiter and sequencer for the shared combinational ALU
//
// Purpose:
//   Grants one of two requesters at a time. The granted op select and operands
//   are registered onto the ALU inputs. The combinational ALU result is captured
//   one cycle later and returned on a single response channel, tagged with the
//   ID of the requester that issued the operation.
//
// Ports:
//   clk, rst_n                      clock (rising edge), asynchronous active-low reset
//   req0_valid/ready/sel/a/b        requester 0 operation channel
//   req1_valid/ready/sel/a/b        requester 1 operation channel
//   alu_sel, alu_a, alu_b           registered inputs to the external ALU
//   alu_out                         combinational ALU result
//   rsp_valid/ready/data/id         response channel
//
// Configuration:
//   ALU_ARB_RR_EN  defined: round-robin on ties. Undefined: requester 0 wins ties.
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2:0]       req0_sel,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [2:0]       req1_sel,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic [2:0]       alu_sel,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_id
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   grant0, grant1;
  logic   handshake;
  logic   gnt_id;

`ifdef ALU_ARB_RR_EN
  // Requester most recently granted; reset to 1 so requester 0 wins the first tie.
  logic last_grant;
`endif

  // Grant from the valids alone; the state gating happens on the readies.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (req0_valid && req1_valid) begin
`ifdef ALU_ARB_RR_EN
      grant0 = last_grant;
      grant1 = !last_grant;
`else
      grant0 = 1'b1;
`endif
    end else begin
      grant0 = req0_valid;
      grant1 = req1_valid;
    end
  end

  // rst_n gates the readies so no handshake is offered while reset is held.
  assign req0_ready = rst_n && (state == IDLE) && grant0;
  assign req1_ready = rst_n && (state == IDLE) && grant1;
  assign handshake  = req0_ready || req1_ready;
  assign rsp_valid  = (state == RESP);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (handshake) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      alu_sel  <= '0;
      alu_a    <= '0;
      alu_b    <= '0;
      gnt_id   <= 1'b0;
      rsp_data <= '0;
      rsp_id   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (handshake) begin
        alu_sel <= grant1 ? req1_sel : req0_sel;
        alu_a   <= grant1 ? req1_a   : req0_a;
        alu_b   <= grant1 ? req1_b   : req0_b;
        gnt_id  <= grant1;
      end
      if (state == EXEC) begin
        rsp_data <= alu_out;
        rsp_id   <= gnt_id;
      end
    end
  end

`ifdef ALU_ARB_RR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
    end else if (handshake) begin
      last_grant <= grant1;
    end
  end
`endif

endmodule
